// File: rtl/logic_sweep_unit.sv
// Exhaustive truth-table generator: streams op(a, b) for every operand pair
// over valid/ready and accumulates the total number of 1-bits produced.
module logic_sweep_unit #(
  parameter  int WIDTH  = 2,
  localparam int CNT_W  = 2 * WIDTH,
  localparam int POP_W  = $clog2(WIDTH + 1),
  localparam int ONES_W = CNT_W + POP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_y,
  output logic              busy,
  output logic              done,
  output logic [ONES_W-1:0] ones_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         op_reg, op_next;
  logic [ONES_W-1:0]  ones_reg, ones_next;
  logic [POP_W-1:0]   pop_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      ones_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      ones_reg  <= ones_next;
    end
  end

  assign out_a = cnt_reg[CNT_W-1:WIDTH];
  assign out_b = cnt_reg[WIDTH-1:0];

  // One bit-slice per operand bit; op_reg selects the 2-input function.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        unique case (op_reg)
          3'd0:    out_y[gi] = out_a[gi] & out_b[gi];
          3'd1:    out_y[gi] = out_a[gi] | out_b[gi];
          3'd2:    out_y[gi] = ~(out_a[gi] & out_b[gi]);
          3'd3:    out_y[gi] = ~(out_a[gi] | out_b[gi]);
          3'd4:    out_y[gi] = out_a[gi] ^ out_b[gi];
          3'd5:    out_y[gi] = ~(out_a[gi] ^ out_b[gi]);
          3'd6:    out_y[gi] = ~out_a[gi] | out_b[gi];
          default: out_y[gi] = out_a[gi] & ~out_b[gi];
        endcase
      end
    end
  endgenerate

  always_comb begin
    pop_y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_y = pop_y + POP_W'(out_y[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    ones_next  = ones_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next    = op;
          cnt_next   = '0;
          ones_next  = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          ones_next = ones_reg + ONES_W'(pop_y);
          // The terminal combination exits instead of wrapping the counter.
          if (cnt_reg == {CNT_W{1'b1}}) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_valid  = (state_reg == ST_RUN);
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign ones_count = ones_reg;

endmodule
